// File: rtl/tetris_game_ctrl.sv
// Game-flow controller for the Tetris datapath: sequences countdown, spawn,
// move/fall, lock, line removal and game over, and tracks lines and level.
module tetris_game_ctrl #(
  parameter int unsigned CNT_W           = 2,
  parameter int unsigned COUNTDOWN       = 3,
  parameter int unsigned PRESCALE        = 4,
  parameter int unsigned TMR_W           = 16,
  parameter int unsigned BASE_DROP       = 1000,
  parameter int unsigned DROP_STEP       = 50,
  parameter int unsigned MIN_DROP        = 100,
  parameter int unsigned LVL_W           = 4,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LINE_W          = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              stop_i,
  input  logic              remove_i,
  input  logic              game_over_i,
  input  logic              done_i,
  output logic              new_en_o,
  output logic              move_en_o,
  output logic              drop_tick_o,
  output logic              transform_en_o,
  output logic              remove_en_o,
  output logic              clear_en_o,
  output logic              paused_o,
  output logic [CNT_W-1:0]  time_up_o,
  output logic [LVL_W-1:0]  level_o,
  output logic [LINE_W-1:0] lines_cleared_o,
  output logic [3:0]        state_o
);

  localparam int unsigned PsW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned LilW = $clog2(LINES_PER_LEVEL + 1);

  typedef enum logic [3:0] {
    StReady    = 4'd0,
    StWait     = 4'd1,
    StNew      = 4'd2,
    StMove     = 4'd3,
    StPause    = 4'd4,
    StStop     = 4'd5,
    StIfRemove = 4'd6,
    StRemove   = 4'd7,
    StOver     = 4'd8,
    StClear    = 4'd9,
    StFinish   = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  time_up_q, time_up_d;
  logic [PsW-1:0]    presc_q, presc_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              drop_tick_q, drop_tick_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LINE_W-1:0] lines_q, lines_d;
  logic [LilW-1:0]   lil_q, lil_d;

  logic [31:0]       dec_w, sat_w, period_w;
  logic [TMR_W-1:0]  drop_last;

  // Level-scaled drop period, saturating at zero before the MIN_DROP floor.
  always_comb begin
    dec_w     = 32'(level_q) * 32'(DROP_STEP);
    sat_w     = (dec_w >= 32'(BASE_DROP)) ? 32'd0 : 32'(BASE_DROP) - dec_w;
    period_w  = (sat_w < 32'(MIN_DROP)) ? 32'(MIN_DROP) : sat_w;
    drop_last = TMR_W'(period_w - 32'd1);
  end

  // Next-state logic for the game FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReady:    if (start_i) state_d = StWait;
      StWait:     if (time_up_q == '0) state_d = StNew;
      StNew:      state_d = StMove;
      StMove: begin
        if (stop_i)       state_d = StStop;
        else if (pause_i) state_d = StPause;
      end
      StPause:    if (pause_i) state_d = StMove;
      StStop:     state_d = StIfRemove;
      StIfRemove, StRemove: begin
        if (remove_i)         state_d = StRemove;
        else if (game_over_i) state_d = StOver;
        else                  state_d = StNew;
      end
      StOver:     state_d = StClear;
      StClear:    if (done_i) state_d = StFinish;
      StFinish:   if (start_i) state_d = StWait;
      default:    state_d = StReady;
    endcase
  end

  // Countdown, gravity timer and line/level counters.
  always_comb begin
    time_up_d   = time_up_q;
    presc_d     = presc_q;
    timer_d     = timer_q;
    drop_tick_d = 1'b0;
    level_d     = level_q;
    lines_d     = lines_q;
    lil_d       = lil_q;

    if ((state_q == StReady || state_q == StFinish) && start_i) begin
      time_up_d = CNT_W'(COUNTDOWN);
      presc_d   = '0;
      if (state_q == StFinish) begin
        level_d = '0;
        lines_d = '0;
        lil_d   = '0;
      end
    end

    if (state_q == StWait && time_up_q != '0) begin
      if (presc_q == PsW'(PRESCALE - 1)) begin
        presc_d   = '0;
        time_up_d = time_up_q - CNT_W'(1);
      end else begin
        presc_d = presc_q + PsW'(1);
      end
    end

    // The tick is suppressed when MOVE is left on the compare cycle so it
    // never appears outside MOVE.
    if (state_q == StMove) begin
      if (timer_q == drop_last) begin
        timer_d     = '0;
        drop_tick_d = (state_d == StMove);
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
    if (state_d == StNew) timer_d = '0;

    if (state_q == StRemove) begin
      if (lines_q != '1) lines_d = lines_q + LINE_W'(1);
      if (lil_q == LilW'(LINES_PER_LEVEL - 1)) begin
        lil_d = '0;
        if (level_q < LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
      end else begin
        lil_d = lil_q + LilW'(1);
      end
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StReady;
      time_up_q   <= '0;
      presc_q     <= '0;
      timer_q     <= '0;
      drop_tick_q <= 1'b0;
      level_q     <= '0;
      lines_q     <= '0;
      lil_q       <= '0;
    end else begin
      state_q     <= state_d;
      time_up_q   <= time_up_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      drop_tick_q <= drop_tick_d;
      level_q     <= level_d;
      lines_q     <= lines_d;
      lil_q       <= lil_d;
    end
  end

  // Moore enables decoded from the current state.
  always_comb begin
    new_en_o       = (state_q == StNew);
    move_en_o      = (state_q == StMove);
    transform_en_o = (state_q == StStop);
    remove_en_o    = (state_q == StRemove);
    clear_en_o     = (state_q == StClear);
    paused_o       = (state_q == StPause);
  end

  assign drop_tick_o     = drop_tick_q;
  assign time_up_o       = time_up_q;
  assign level_o         = level_q;
  assign lines_cleared_o = lines_q;
  assign state_o         = state_q;

endmodule
